// File: rtl/tl_memory.sv
// MEM stage: byte/half/word data-memory access, BEQ/BNE resolution, MEM/WB register, debug read port.
// Latency: one stage (registered on negedge i_clk); branch outputs combinational.
// Backpressure: none, accepts a new EX/MEM bundle every cycle.
module tl_memory #(
   parameter int LEN                  = 32,
   parameter int NB_ADDRESS_REGISTROS = 5,
   parameter int NB_CTRL_WB           = 2,
   parameter int NB_CTRL_MEM          = 9,
   parameter int NB_DEPTH             = 10
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [LEN-1:0]                  i_add_execute,
   input  logic [LEN-1:0]                  i_alu_result,
   input  logic [LEN-1:0]                  i_dato2,
   input  logic                            i_alu_zero,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
   input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
   input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
   input  logic [NB_DEPTH-1:0]             i_debug_addr,
   output logic                            o_pc_src,
   output logic [LEN-1:0]                  o_branch_target,
   output logic [LEN-1:0]                  o_read_data,
   output logic [LEN-1:0]                  o_alu_result,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
   output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
   output logic                            o_misaligned,
   output logic [LEN-1:0]                  o_debug_data
);

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [LEN-1:0] mem [0:(1<<NB_DEPTH)-1];

   logic                branch_eq;
   logic                branch_ne;
   logic                mem_read;
   logic                mem_write;
   logic [1:0]          size;
   logic                is_unsigned;
   logic [NB_DEPTH-1:0] word_idx;
   logic [1:0]          lane;
   logic                misaligned;
   logic [3:0]          byte_en;
   logic [31:0]         wr_data;
   logic [31:0]         rd_word;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [LEN-1:0]      load_data;
   logic                unused_bits;

   assign branch_eq   = i_ctrl_mem[8];
   assign branch_ne   = i_ctrl_mem[7];
   assign mem_read    = i_ctrl_mem[6];
   assign mem_write   = i_ctrl_mem[5];
   assign size        = i_ctrl_mem[4:3];
   assign is_unsigned = i_ctrl_mem[2];
   assign word_idx    = i_alu_result[NB_DEPTH+1:2];
   assign lane        = i_alu_result[1:0];
   assign unused_bits = ^{i_ctrl_mem[1:0], i_alu_result[LEN-1:NB_DEPTH+2]};

   // Size 11 is reserved and treated as misaligned so it can never touch memory.
   assign misaligned = (mem_read | mem_write) &
                       (((size == SZ_H) & lane[0]) |
                        ((size == SZ_W) & (lane != 2'b00)) |
                        (size == 2'b11));

   always_comb begin
      byte_en = 4'b0000;
      wr_data = i_dato2;
      case (size)
         SZ_B: begin
            byte_en       = 4'b0001 << lane;
            wr_data       = {4{i_dato2[7:0]}};
         end
         SZ_H: begin
            byte_en       = lane[1] ? 4'b1100 : 4'b0011;
            wr_data       = {2{i_dato2[15:0]}};
         end
         SZ_W: byte_en    = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   // Stores land mid-stage so the negedge capture below already sees them.
   always_ff @(posedge i_clk) begin
      if (i_rst && mem_write && !misaligned) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign rd_word = mem[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_data = '0;
      if (mem_read && !misaligned) begin
         case (size)
            SZ_B:    load_data = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
            SZ_H:    load_data = {{16{~is_unsigned & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
         endcase
      end
   end

   always_ff @(negedge i_clk) begin
      if (!i_rst) begin
         o_read_data  <= '0;
         o_alu_result <= '0;
         o_write_reg  <= '0;
         o_ctrl_wb    <= '0;
         o_misaligned <= 1'b0;
      end else begin
         o_read_data  <= load_data;
         o_alu_result <= i_alu_result;
         o_write_reg  <= i_write_reg;
         o_ctrl_wb    <= i_ctrl_wb;
         o_misaligned <= misaligned;
      end
   end

   assign o_pc_src        = i_rst & ((branch_eq & i_alu_zero) | (branch_ne & ~i_alu_zero));
   assign o_branch_target = i_add_execute;
   assign o_debug_data    = mem[i_debug_addr];

endmodule

// File: tb/tb_tl_memory.sv
// Directed bench for tl_memory: inputs change just after negedge, outputs checked 1ns after the next negedge.
module tb_tl_memory;

   logic        clk;
   logic        rst;
   logic [31:0] add_execute;
   logic [31:0] alu_result;
   logic [31:0] dato2;
   logic        alu_zero;
   logic [4:0]  write_reg;
   logic [1:0]  ctrl_wb;
   logic [8:0]  ctrl_mem;
   logic [9:0]  debug_addr;
   logic        pc_src;
   logic [31:0] branch_target;
   logic [31:0] read_data;
   logic [31:0] alu_result_q;
   logic [4:0]  write_reg_q;
   logic [1:0]  ctrl_wb_q;
   logic        misaligned_q;
   logic [31:0] debug_data;

   int total;
   int bad;

   tl_memory dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_add_execute   (add_execute),
      .i_alu_result    (alu_result),
      .i_dato2         (dato2),
      .i_alu_zero      (alu_zero),
      .i_write_reg     (write_reg),
      .i_ctrl_wb       (ctrl_wb),
      .i_ctrl_mem      (ctrl_mem),
      .i_debug_addr    (debug_addr),
      .o_pc_src        (pc_src),
      .o_branch_target (branch_target),
      .o_read_data     (read_data),
      .o_alu_result    (alu_result_q),
      .o_write_reg     (write_reg_q),
      .o_ctrl_wb       (ctrl_wb_q),
      .o_misaligned    (misaligned_q),
      .o_debug_data    (debug_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

   function automatic logic [8:0] mc(input logic br, input logic bne, input logic rd,
                                     input logic wr, input logic [1:0] sz, input logic uns);
      return {br, bne, rd, wr, sz, uns, 2'b00};
   endfunction

   // Presents one EX/MEM bundle and advances past the capturing negedge.
   task automatic cyc(input logic [8:0] c, input logic [31:0] addr, input logic [31:0] d);
      ctrl_mem   = c;
      alu_result = addr;
      dato2      = d;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; alu_zero = 1'b1; write_reg = 5'd7; ctrl_wb = 2'b11; add_execute = 32'h100;
      cyc(mc(1, 0, 1, 1, W, 0), 32'h0, 32'hCAFEF00D);
      cyc(mc(1, 0, 1, 1, W, 0), 32'h0, 32'hCAFEF00D);
      total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_read_data got=%h exp=0", read_data); end
      total++; if (alu_result_q !== 32'h0) begin bad++; $display("FAIL rst_alu_result got=%h exp=0", alu_result_q); end
      total++; if (write_reg_q !== 5'd0) begin bad++; $display("FAIL rst_write_reg got=%h exp=0", write_reg_q); end
      total++; if (ctrl_wb_q !== 2'd0) begin bad++; $display("FAIL rst_ctrl_wb got=%h exp=0", ctrl_wb_q); end
      total++; if (misaligned_q !== 1'b0) begin bad++; $display("FAIL rst_misaligned got=%b exp=0", misaligned_q); end
      total++; if (pc_src !== 1'b0) begin bad++; $display("FAIL rst_pc_src got=%b exp=0", pc_src); end
      // Seed word 0, then confirm a store issued under reset is dropped.
      rst = 1'b1; alu_zero = 1'b0;
      cyc(mc(0, 0, 0, 1, W, 0), 32'h0, 32'h11111111);
      rst = 1'b0;
      cyc(mc(0, 0, 0, 1, W, 0), 32'h0, 32'hDEADBEEF);
      cyc(mc(0, 0, 0, 1, W, 0), 32'h0, 32'hDEADBEEF);
      debug_addr = 10'd0; #1;
      total++; if (debug_data !== 32'h11111111) begin bad++; $display("FAIL rst_mem_kept got=%h exp=11111111", debug_data); end
      rst = 1'b1;
   endtask

   task automatic test_word;
      write_reg = 5'd3; ctrl_wb = 2'b10;
      cyc(mc(0, 0, 0, 1, W, 0), 32'h10, 32'h8899AABB);
      total++; if (misaligned_q !== 1'b0) begin bad++; $display("FAIL sw_misaligned got=%b exp=0", misaligned_q); end
      total++; if (alu_result_q !== 32'h10) begin bad++; $display("FAIL sw_alu_result got=%h exp=10", alu_result_q); end
      total++; if (write_reg_q !== 5'd3) begin bad++; $display("FAIL sw_write_reg got=%h exp=3", write_reg_q); end
      total++; if (ctrl_wb_q !== 2'b10) begin bad++; $display("FAIL sw_ctrl_wb got=%b exp=10", ctrl_wb_q); end
      cyc(mc(0, 0, 1, 0, W, 0), 32'h10, 32'h0);
      total++; if (read_data !== 32'h8899AABB) begin bad++; $display("FAIL lw got=%h exp=8899aabb", read_data); end
      total++; if (misaligned_q !== 1'b0) begin bad++; $display("FAIL lw_misaligned got=%b exp=0", misaligned_q); end
   endtask

   task automatic test_subword_load;
      cyc(mc(0, 0, 1, 0, B, 0), 32'h11, 32'h0);
      total++; if (read_data !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb got=%h exp=ffffffaa", read_data); end
      cyc(mc(0, 0, 1, 0, B, 1), 32'h11, 32'h0);
      total++; if (read_data !== 32'h000000AA) begin bad++; $display("FAIL lbu got=%h exp=000000aa", read_data); end
      cyc(mc(0, 0, 1, 0, H, 0), 32'h12, 32'h0);
      total++; if (read_data !== 32'hFFFF8899) begin bad++; $display("FAIL lh got=%h exp=ffff8899", read_data); end
      cyc(mc(0, 0, 1, 0, H, 1), 32'h12, 32'h0);
      total++; if (read_data !== 32'h00008899) begin bad++; $display("FAIL lhu got=%h exp=00008899", read_data); end
      cyc(mc(0, 0, 1, 0, B, 0), 32'h10, 32'h0);
      total++; if (read_data !== 32'hFFFFFFBB) begin bad++; $display("FAIL lb_lane0 got=%h exp=ffffffbb", read_data); end
      cyc(mc(0, 0, 1, 0, H, 0), 32'h10, 32'h0);
      total++; if (read_data !== 32'hFFFFAABB) begin bad++; $display("FAIL lh_low got=%h exp=ffffaabb", read_data); end
   endtask

   task automatic test_partial_store;
      cyc(mc(0, 0, 0, 1, B, 0), 32'h13, 32'hFFFFFF55);
      cyc(mc(0, 0, 1, 0, W, 0), 32'h10, 32'h0);
      total++; if (read_data !== 32'h5599AABB) begin bad++; $display("FAIL sb_lw got=%h exp=5599aabb", read_data); end
      cyc(mc(0, 0, 0, 1, H, 0), 32'h10, 32'hABCD1234);
      cyc(mc(0, 0, 1, 0, W, 0), 32'h10, 32'h0);
      total++; if (read_data !== 32'h55991234) begin bad++; $display("FAIL sh_lw got=%h exp=55991234", read_data); end
   endtask

   task automatic test_misaligned;
      cyc(mc(0, 0, 0, 1, W, 0), 32'h0, 32'h01020304);
      cyc(mc(0, 0, 0, 1, W, 0), 32'h2, 32'hFFFFFFFF);
      total++; if (misaligned_q !== 1'b1) begin bad++; $display("FAIL sw_mis_flag got=%b exp=1", misaligned_q); end
      debug_addr = 10'd0; #1;
      total++; if (debug_data !== 32'h01020304) begin bad++; $display("FAIL sw_mis_nowrite got=%h exp=01020304", debug_data); end
      cyc(mc(0, 0, 1, 0, W, 0), 32'h1000, 32'h0);
      total++; if (read_data !== 32'h01020304) begin bad++; $display("FAIL lw_wrap got=%h exp=01020304", read_data); end
      total++; if (misaligned_q !== 1'b0) begin bad++; $display("FAIL lw_wrap_flag got=%b exp=0", misaligned_q); end
      cyc(mc(0, 0, 1, 0, H, 0), 32'h3, 32'h0);
      total++; if (read_data !== 32'h0 || misaligned_q !== 1'b1) begin
         bad++; $display("FAIL lh_mis got=%h/%b exp=0/1", read_data, misaligned_q); end
      cyc(mc(0, 0, 1, 0, R, 0), 32'h0, 32'h0);
      total++; if (read_data !== 32'h0 || misaligned_q !== 1'b1) begin
         bad++; $display("FAIL rsvd_size got=%h/%b exp=0/1", read_data, misaligned_q); end
      cyc(mc(0, 0, 0, 0, W, 0), 32'h2, 32'h0);
      total++; if (misaligned_q !== 1'b0) begin bad++; $display("FAIL no_access_flag got=%b exp=0", misaligned_q); end
   endtask

   task automatic test_back_to_back;
      cyc(mc(0, 0, 1, 1, W, 0), 32'h20, 32'hA5A5A5A5);
      total++; if (read_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL rw_same got=%h exp=a5a5a5a5", read_data); end
      cyc(mc(0, 0, 0, 1, W, 0), 32'h24, 32'h0BADF00D);
      cyc(mc(0, 0, 1, 0, W, 0), 32'h24, 32'h0);
      total++; if (read_data !== 32'h0BADF00D) begin bad++; $display("FAIL st_then_ld got=%h exp=0badf00d", read_data); end
      cyc(mc(0, 0, 0, 0, W, 0), 32'h24, 32'h0);
      total++; if (read_data !== 32'h0) begin bad++; $display("FAIL noread got=%h exp=0", read_data); end
      debug_addr = 10'd8; #1;
      total++; if (debug_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL debug_rd got=%h exp=a5a5a5a5", debug_data); end
   endtask

   task automatic test_branch;
      logic [2:0] vec [6];
      logic       exp [6];
      vec[0] = 3'b101; exp[0] = 1'b1;  // {branch, branch_ne, zero}
      vec[1] = 3'b100; exp[1] = 1'b0;
      vec[2] = 3'b011; exp[2] = 1'b0;
      vec[3] = 3'b010; exp[3] = 1'b1;
      vec[4] = 3'b110; exp[4] = 1'b1;
      vec[5] = 3'b001; exp[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         add_execute = 32'h400 + 32'(i * 4);
         alu_zero    = vec[i][0];
         ctrl_mem    = mc(vec[i][2], vec[i][1], 0, 0, W, 0);
         #1;
         total++; if (pc_src !== exp[i]) begin bad++; $display("FAIL pc_src[%0d] got=%b exp=%b", i, pc_src, exp[i]); end
         total++; if (branch_target !== 32'h400 + 32'(i * 4)) begin
            bad++; $display("FAIL target[%0d] got=%h exp=%h", i, branch_target, 32'h400 + 32'(i * 4)); end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; add_execute = '0; alu_result = '0; dato2 = '0; alu_zero = 1'b0;
      write_reg = '0; ctrl_wb = '0; ctrl_mem = '0; debug_addr = '0;
      test_reset;
      test_word;
      test_subword_load;
      test_partial_store;
      test_misaligned;
      test_back_to_back;
      test_branch;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
